config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//  Sequencer for one config_tile shift chain. Accepts a configuration bitstream as
//  WORD_W-bit words (valid/ready) and serialises CHAIN_LEN bits MSB-first onto
//  shift_in_hard or shift_in_soft under shift_enable. It then pulses the matching set
//  strobe and reports done. Old chain contents leaving shift_out are returned as
//  readback words. Sits between the bitstream host/DMA and the config_tile array.
// PARAMETERS
//  CHAIN_LEN   10                       total chain bits (comb_N + mem_N)
//  WORD_W      8                        bits per input/readback word
//  SET_CYCLES  1                        cycles set_hard/set_soft is held high
//  CNT_W       $clog2(CHAIN_LEN+1)      remaining-bit counter width
// PORTS
//  clk            in   1       clock; all state on rising edge
//  rst            in   1       asynchronous, active-high reset
//  start          in   1       begin a load; sampled only in IDLE
//  target_soft    in   1       0: hard chain, 1: soft chain; latched with start
//  in_data        in   WORD_W  bitstream word; bit WORD_W-1 is shifted first
//  in_valid       in   1       in_data valid
//  in_ready       out  1       word accepted when in_valid & in_ready
//  shift_enable   out  1       chain shift enable
//  shift_in_hard  out  1       serial data, hard chain
//  shift_in_soft  out  1       serial data, soft chain
//  set_hard       out  1       latch hard chain into config latches
//  set_soft       out  1       latch soft chain into config latches
//  shift_out      in   1       chain serial output, for readback
//  rb_data        out  WORD_W  readback word; first captured bit in MSB
//  rb_valid       out  1       1-cycle pulse, rb_data valid; no backpressure
//  busy           out  1       high in any state except IDLE
//  done           out  1       1-cycle pulse at end of load
// BEHAVIOUR
//  - All outputs registered. On rst, every output is 0, FSM = IDLE, and counters are 0.
//    Asserting rst mid-load aborts immediately. No set strobe is issued and the chain keeps its partial shift.
//  - FSM: IDLE -start-> LOAD; LOAD -(in_valid&in_ready)-> SHIFT;
//    SHIFT -(word bits exhausted & remaining>0)-> LOAD; SHIFT -(remaining==0)-> SET;
//    SET -(SET_CYCLES elapsed)-> DONE; DONE -> IDLE (unconditional, 1 cycle).
//  - start: ignored while busy. target_soft is latched on the start cycle.
//  - in_ready is 1 only in LOAD. Each LOAD costs at least 1 cycle, so no back-to-back accept.
//  - SHIFT: one bit per cycle with shift_enable=1. Bits per word = min(WORD_W, remaining).
//    The last word uses its top `remaining` bits; the lower bits are ignored.
//  - Data drives only the selected shift_in_*; the other shift_in_* is held at 0.
//    Both are 0 outside SHIFT. shift_enable is 0 in IDLE, LOAD, SET and DONE.
//  - Bit order: the first bit shifted is config bit CHAIN_LEN-1. After a full load, the tile holds
//    comb_config = cfg[comb_N-1:0] and mem_config = cfg[CHAIN_LEN-1:comb_N].
//  - Readback: shift_out is sampled on every SHIFT cycle into rb shift register (MSB first).
//    rb_valid pulses on the cycle after the word's last shift.
//    For a partial last word, captured bits are MSB-aligned and the rest are 0.
//  - SET: selected set_* is high for exactly SET_CYCLES cycles and the other set_* stays 0.
//    done pulses in the following cycle (DONE), and busy drops together with done's falling cycle.
//  - Latency with in_valid held high: start -> done =
//    1 + sum over words (1 + bits) + SET_CYCLES + 1 cycles.
//    Example, defaults: 1+9+3+1+1 = 15.
//  - CHAIN_LEN < WORD_W is legal (a single partial word). CHAIN_LEN == 0 is illegal (elaboration error).
// STRUCTURE
//  - config_ctrl_pkg: FSM state localparams (IDLE, LOAD, SHIFT, SET, DONE), clog2 function.
//  - Sub-module config_word_serializer: WORD_W PISO with load/shift/bit-count, reused for
//    the data path. The readback SIPO is inline. The FSM and counters live in the top level.
// TESTING (CHAIN_LEN=10, WORD_W=8, SET_CYCLES=1, with a config_tile comb_N=5 mem_N=5)
//  - Hard load of cfg=10'b1010110100: words 8'hAD, 8'h00 -> 10 shifts on shift_in_hard,
//    set_hard for 1 cycle -> comb_config=5'b10100, mem_config=5'b10101, done at cycle 15.
//  - Soft load of cfg=10'b0111010001 (8'h74, 8'h40) -> shift_in_hard stays 0, only set_soft
//    pulses. Readback of the previous soft contents on rb_data/rb_valid (2 pulses).
//  - in_valid stalled 5 cycles before word 2 -> shift_enable=0 during stall, chain frozen,
//    final config identical to the no-stall case.
//  - start pulsed while busy, and in_valid high in IDLE -> both ignored, no extra accepts.
//  - rst asserted after 4 shifts -> all outputs 0 asynchronously, no set_* pulse.
//    A fresh load then completes correctly.
//  - Back-to-back loads: start on the DONE cycle is ignored. Start one cycle later is accepted.
//    Readback of load 2 equals cfg of load 1 (8'hAD, 8'h00).

Source files
------------

// File: rtl/config_ctrl_pkg.sv
// Shared FSM encodings and width helper for the config chain loader.
package config_ctrl_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] SET   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Parallel-in/serial-out word register with a remaining-bit count for the current word.
module config_word_serializer
    import config_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [LEN_W-1:0]  nbits,
    input  logic              shift,
    output logic              bit_nxt,
    output logic              last
);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]  left_q, left_d;

    always_comb begin
        sr_d   = sr_q;
        left_d = left_q;
        if (load) begin
            sr_d   = data;
            left_d = nbits;
        end else if (shift) begin
            sr_d = sr_q << 1;
            if (left_q != '0) left_d = left_q - 1'b1;
        end
    end

    // Exposes the bit that will sit in the MSB next cycle so the caller can register it.
    assign bit_nxt = sr_d[WORD_W-1];
    assign last    = (left_q == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            left_q <= '0;
        end else begin
            sr_q   <= sr_d;
            left_q <= left_d;
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Loads one config_tile shift chain from a word stream, pulses its set strobe and
// returns the displaced chain contents as readback words.
module config_chain_loader
    import config_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = 10,
    parameter int WORD_W     = 8,
    parameter int SET_CYCLES = 1,
    parameter int CNT_W      = clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              target_soft,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_enable,
    output logic              shift_in_hard,
    output logic              shift_in_soft,
    output logic              set_hard,
    output logic              set_soft,
    input  logic              shift_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int LEN_W = clog2(WORD_W + 1);
    localparam int IDX_W = (clog2(WORD_W) > 0) ? clog2(WORD_W) : 1;
    localparam int SC_W  = (clog2(SET_CYCLES) > 0) ? clog2(SET_CYCLES) : 1;

    if (CHAIN_LEN < 1) begin : g_bad_chain_len
        $error("config_chain_loader: CHAIN_LEN must be at least 1");
    end
    if (SET_CYCLES < 1) begin : g_bad_set_cycles
        $error("config_chain_loader: SET_CYCLES must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic              target_q, target_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [SC_W-1:0]   set_cnt_q, set_cnt_d;
    logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
    logic [IDX_W-1:0]  rb_idx_q, rb_idx_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              shift_enable_q, shift_enable_d;
    logic              shift_in_hard_q, shift_in_hard_d;
    logic              shift_in_soft_q, shift_in_soft_d;
    logic              set_hard_q, set_hard_d;
    logic              set_soft_q, set_soft_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ser_load, ser_shift, ser_bit_nxt, ser_last;
    logic [LEN_W-1:0]  ser_nbits;
    logic [WORD_W-1:0] rb_word;
    logic [IDX_W-1:0]  rb_pos;

    config_word_serializer #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .data    (in_data),
        .nbits   (ser_nbits),
        .shift   (ser_shift),
        .bit_nxt (ser_bit_nxt),
        .last    (ser_last)
    );

    always_comb begin
        if (int'(remaining_q) < WORD_W) ser_nbits = LEN_W'(remaining_q);
        else                            ser_nbits = LEN_W'(WORD_W);
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        remaining_d = remaining_q;
        set_cnt_d   = set_cnt_q;
        rb_sr_d     = rb_sr_q;
        rb_idx_d    = rb_idx_q;
        rb_data_d   = rb_data_q;
        rb_valid_d  = 1'b0;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        // Captured bits fill from the MSB down, so a short last word is left-aligned.
        rb_pos          = IDX_W'(WORD_W - 1) - rb_idx_q;
        rb_word         = rb_sr_q;
        rb_word[rb_pos] = shift_out;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    target_d    = target_soft;
                    remaining_d = CNT_W'(CHAIN_LEN);
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    state_d  = SHIFT;
                    ser_load = 1'b1;
                    rb_sr_d  = '0;
                    rb_idx_d = '0;
                end
            end
            SHIFT: begin
                ser_shift   = 1'b1;
                remaining_d = remaining_q - 1'b1;
                rb_sr_d     = rb_word;
                rb_idx_d    = rb_idx_q + 1'b1;
                if (ser_last) begin
                    rb_data_d  = rb_word;
                    rb_valid_d = 1'b1;
                    set_cnt_d  = '0;
                    state_d    = (remaining_q == CNT_W'(1)) ? SET : LOAD;
                end
            end
            SET: begin
                if (int'(set_cnt_q) == SET_CYCLES - 1) state_d = DONE;
                else                                   set_cnt_d = set_cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        busy_d          = (state_d != IDLE);
        in_ready_d      = (state_d == LOAD);
        shift_enable_d  = (state_d == SHIFT);
        shift_in_hard_d = shift_enable_d && !target_d && ser_bit_nxt;
        shift_in_soft_d = shift_enable_d &&  target_d && ser_bit_nxt;
        set_hard_d      = (state_d == SET) && !target_d;
        set_soft_d      = (state_d == SET) &&  target_d;
        done_d          = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            target_q        <= 1'b0;
            remaining_q     <= '0;
            set_cnt_q       <= '0;
            rb_sr_q         <= '0;
            rb_idx_q        <= '0;
            rb_data_q       <= '0;
            rb_valid_q      <= 1'b0;
            in_ready_q      <= 1'b0;
            shift_enable_q  <= 1'b0;
            shift_in_hard_q <= 1'b0;
            shift_in_soft_q <= 1'b0;
            set_hard_q      <= 1'b0;
            set_soft_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            remaining_q     <= remaining_d;
            set_cnt_q       <= set_cnt_d;
            rb_sr_q         <= rb_sr_d;
            rb_idx_q        <= rb_idx_d;
            rb_data_q       <= rb_data_d;
            rb_valid_q      <= rb_valid_d;
            in_ready_q      <= in_ready_d;
            shift_enable_q  <= shift_enable_d;
            shift_in_hard_q <= shift_in_hard_d;
            shift_in_soft_q <= shift_in_soft_d;
            set_hard_q      <= set_hard_d;
            set_soft_q      <= set_soft_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign shift_enable  = shift_enable_q;
    assign shift_in_hard = shift_in_hard_q;
    assign shift_in_soft = shift_in_soft_q;
    assign set_hard      = set_hard_q;
    assign set_soft      = set_soft_q;
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader driving a behavioural config_tile (comb_N=5, mem_N=5).
module tb_config_chain_loader;

    logic       clk = 1'b0;
    logic       rst, start, target_soft, in_valid;
    logic [7:0] in_data;
    logic       in_ready, shift_enable, shift_in_hard, shift_in_soft;
    logic       set_hard, set_soft, shift_out, rb_valid, busy, done;
    logic [7:0] rb_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    config_chain_loader #(
        .CHAIN_LEN  (10),
        .WORD_W     (8),
        .SET_CYCLES (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .target_soft   (target_soft),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .shift_enable  (shift_enable),
        .shift_in_hard (shift_in_hard),
        .shift_in_soft (shift_in_soft),
        .set_hard      (set_hard),
        .set_soft      (set_soft),
        .shift_out     (shift_out),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural tile: each chain shifts only while it is the addressed one.
    logic [9:0] chain_h = '0, chain_s = '0;
    logic [4:0] comb_h = '0, mem_h = '0, comb_s = '0, mem_s = '0;
    logic       tile_tgt = 1'b0;
    logic [9:0] gold_h = '0, gold_s = '0;

    always @(posedge clk) begin
        if (shift_enable) begin
            if (tile_tgt) chain_s <= {chain_s[8:0], shift_in_soft};
            else          chain_h <= {chain_h[8:0], shift_in_hard};
        end
        if (set_hard) begin comb_h <= chain_h[4:0]; mem_h <= chain_h[9:5]; end
        if (set_soft) begin comb_s <= chain_s[4:0]; mem_s <= chain_s[9:5]; end
    end
    assign shift_out = tile_tgt ? chain_s[9] : chain_h[9];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] rbq[$];
    int n_shift = 0, n_acc = 0, n_seth = 0, n_sets = 0, n_inh = 0, n_ins = 0, n_stray = 0, n_rb = 0;

    always @(posedge clk) if (in_valid && in_ready) n_acc++;

    always @(negedge clk) begin
        if (shift_enable) n_shift++;
        if (set_hard) n_seth++;
        if (set_soft) n_sets++;
        if (shift_in_hard) n_inh++;
        if (shift_in_soft) n_ins++;
        if (!shift_enable && (shift_in_hard || shift_in_soft)) n_stray++;
        if (rb_valid) begin
            n_rb++;
            check_eq("rb_expected", rbq.size() != 0, 1);
            if (rbq.size() != 0) check_eq("rb_data", rb_data, rbq.pop_front());
        end
    end

    function automatic logic [16:0] out_vec();
        return {busy, in_ready, shift_enable, shift_in_hard, shift_in_soft,
                set_hard, set_soft, done, rb_valid, rb_data};
    endfunction

    // Called at a negedge; start is raised immediately.
    task automatic do_load(input logic [9:0] cfg, input logic tgt, input int stall, input logic hold_start);
        logic [9:0] old, frozen;
        logic [7:0] w [2];
        int t0, k;
        int s_shift, s_acc, s_seth, s_sets, s_inh, s_ins, s_stray, s_rb;
        old = tgt ? gold_s : gold_h;
        rbq.push_back(old[9:2]);
        rbq.push_back({old[1:0], 6'b0});
        w[0] = cfg[9:2];
        w[1] = {cfg[1:0], 6'($urandom)};
        s_shift = n_shift; s_acc = n_acc; s_seth = n_seth; s_sets = n_sets;
        s_inh = n_inh; s_ins = n_ins; s_stray = n_stray; s_rb = n_rb;
        tile_tgt    = tgt;
        start       = 1'b1;
        target_soft = tgt;
        t0          = cyc;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        target_soft = ~tgt;
        for (int i = 0; i < 2; i++) begin
            if (i == 1 && stall > 0) begin
                in_valid = 1'b0;
                k = 0;
                while (!in_ready && k < 40) begin @(negedge clk); k++; end
                frozen = tgt ? chain_s : chain_h;
                repeat (stall) begin
                    check_eq("stall_shift_enable", shift_enable, 0);
                    @(negedge clk);
                end
                check_eq("stall_chain_frozen", tgt ? chain_s : chain_h, frozen);
            end
            in_data  = w[i];
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 40) begin @(negedge clk); k++; end
            check_eq("accept_wait", k < 40, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        k = 0;
        while (!done && k < 60) begin @(negedge clk); k++; end
        check_eq("done_seen", done, 1);
        check_eq("latency", cyc - t0 + 1, 15 + stall);
        check_eq("busy_at_done", busy, 1);
        check_eq("shift_count", n_shift - s_shift, 10);
        check_eq("accept_count", n_acc - s_acc, 2);
        check_eq("set_sel", tgt ? n_sets - s_sets : n_seth - s_seth, 1);
        check_eq("set_other", tgt ? n_seth - s_seth : n_sets - s_sets, 0);
        check_eq("shift_in_other", tgt ? n_inh - s_inh : n_ins - s_ins, 0);
        check_eq("shift_in_stray", n_stray - s_stray, 0);
        check_eq("rb_count", n_rb - s_rb, 2);
        check_eq("rb_queue_drained", rbq.size(), 0);
        check_eq("comb_config", tgt ? comb_s : comb_h, cfg[4:0]);
        check_eq("mem_config", tgt ? mem_s : mem_h, cfg[9:5]);
        if (tgt) gold_s = cfg; else gold_h = cfg;
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_after_done", busy, 0);
        if (hold_start) start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] old, cfg;
        int k, s_acc, s_seth, s_sets;
        rst = 1'b1; start = 1'b0; target_soft = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        check_eq("reset_outputs", out_vec(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // in_valid in IDLE must not be accepted
        s_acc = n_acc;
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) begin @(negedge clk); check_eq("idle_in_ready", in_ready, 0); end
        check_eq("idle_accepts", n_acc - s_acc, 0);
        check_eq("idle_busy", busy, 0);
        in_valid = 1'b0;
        @(negedge clk);

        do_load(10'b1010110100, 1'b0, 0, 1'b0);
        // start held high across the whole load and its DONE cycle
        do_load(10'b0111010001, 1'b1, 0, 1'b1);
        // back-to-back: start on the cycle after DONE
        do_load(10'b0011001110, 1'b0, 0, 1'b0);
        do_load(10'b0111010001, 1'b1, 5, 1'b0);

        // abort after 4 shifts
        old = gold_h; cfg = 10'b1100101011;
        rbq.push_back(old[9:2]);
        rbq.push_back({old[1:0], 6'b0});
        s_seth = n_seth; s_sets = n_sets;
        tile_tgt = 1'b0; start = 1'b1; target_soft = 1'b0;
        @(negedge clk);
        start = 1'b0; in_data = cfg[9:2]; in_valid = 1'b1;
        k = 0;
        while (!shift_enable && k < 20) begin @(negedge clk); k++; end
        check_eq("abort_shift_seen", shift_enable, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_outputs", out_vec(), 0);
        in_valid = 1'b0;
        gold_h = {old[5:0], cfg[9:6]};
        check_eq("abort_chain_partial", chain_h, gold_h);
        check_eq("abort_no_set", (n_seth - s_seth) + (n_sets - s_sets), 0);
        check_eq("abort_no_readback", rbq.size(), 2);
        rbq.delete();
        repeat (2) @(negedge clk);
        check_eq("abort_outputs_held", out_vec(), 0);
        rst = 1'b0;
        @(negedge clk);

        do_load(10'b0101100110, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_load(10'($urandom), 1'($urandom), (i % 2) * 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
